rv_exec_pipe: RTL and testbench

Parametrised two-stage integer execute/writeback unit for the RV32I datapath. It sits directly after the instruction decoder and takes over the register-file role. It accepts one decoded ALU instruction per cycle through a valid/ready handshake, reads operands with WB-to-EX bypass, computes the result, and retires it to an internal register file. Output backpressure stalls the whole pipe.

---
 rtl/rv_exec_pipe.sv | 138 +++++++++++++
 tb/tb_rv_exec_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rv_exec_pipe.sv
// rv_exec_pipe: two-stage RV32I integer execute/writeback unit.
// S1 (EX) captures decoded fields and computes the ALU result with
// WB-to-EX bypass; S2 (WB) holds the result and retires it into the
// internal register file. Output backpressure freezes both stages.
module rv_exec_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 32,
  localparam int RW  = $clog2(NREG),
  localparam int SW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RW-1:0]   oprs1,
  input  logic [RW-1:0]   oprs2,
  input  logic [RW-1:0]   oprd,
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RW-1:0]   out_rd,
  output logic [CNTW-1:0] retire_cnt,
  input  logic [RW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int STAGES = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_PASB = 4'd10;

  typedef struct packed {
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [3:0]      op;
    logic [XLEN-1:0] imm;
    logic            use_imm;
  } ex_req_t;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_rsp_t;

  // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid
  logic [STAGES:1] vld_pipe;
  ex_req_t         s1;
  wb_rsp_t         s2;
  logic [XLEN-1:0] rf [NREG];

  logic            stall;
  logic            retire;
  logic [XLEN-1:0] op_a, op_b, rs2_val, alu_res;
  logic [SW-1:0]   shamt;

  assign stall    = vld_pipe[2] & ~out_ready;
  assign in_ready = ~stall;
  assign retire   = vld_pipe[2] & out_ready;

  assign out_valid = vld_pipe[2];
  assign out_data  = s2.data;
  assign out_rd    = s2.rd;

  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  // Operand fetch: the WB result wins over the register file so a
  // dependent instruction right behind its producer needs no bubble.
  always_comb begin
    op_a    = '0;
    rs2_val = '0;
    if (s1.rs1 != '0)
      op_a = (vld_pipe[2] && s2.rd == s1.rs1) ? s2.data : rf[s1.rs1];
    if (s1.rs2 != '0)
      rs2_val = (vld_pipe[2] && s2.rd == s1.rs2) ? s2.data : rf[s1.rs2];
    op_b  = s1.use_imm ? s1.imm : rs2_val;
    shamt = op_b[SW-1:0];
  end

  // ALU; unassigned opcodes still retire with a zero result
  always_comb begin
    alu_res = '0;
    case (s1.op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_PASB: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Pipeline advance; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else if (!stall) begin
      vld_pipe[1] <= in_valid;
      vld_pipe[2] <= vld_pipe[1];
      s1          <= '{rs1: oprs1, rs2: oprs2, rd: oprd, op: aluop,
                       imm: imm, use_imm: use_imm};
      s2          <= '{rd: s1.rd, data: alu_res};
    end
  end

  // Retire: write back (x0 never stored) and count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      retire_cnt <= '0;
    end else if (retire) begin
      if (s2.rd != '0) rf[s2.rd] <= s2.data;
      retire_cnt <= retire_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_rv_exec_pipe.sv
// Directed self-checking bench for rv_exec_pipe.
module tb_rv_exec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  oprs1, oprs2, oprd;
  logic [3:0]  aluop;
  logic [31:0] imm;
  logic        use_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [31:0] retire_cnt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  rv_exec_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .oprs1(oprs1), .oprs2(oprs2), .oprd(oprd),
    .aluop(aluop), .imm(imm), .use_imm(use_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .retire_cnt(retire_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [3:0] op, input logic [31:0] im, input logic ui);
    in_valid = 1'b1; oprd = rd; oprs1 = rs1; oprs2 = rs2;
    aluop = op; imm = im; use_imm = ui;
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Signed/logic op table; entry 0 sets x1 = 0xFFFF_FFF0, rest read x1
  logic [3:0]  v_op  [12] = '{4'd0, 4'd7, 4'd6, 4'd3, 4'd4, 4'd2, 4'd5, 4'd8,
                              4'd9, 4'd10, 4'd12, 4'd1};
  logic [31:0] v_imm [12] = '{32'hFFFF_FFF0, 32'd4, 32'd4, 32'd1, 32'd1, 32'd4,
                              32'h0F0F_0F0F, 32'h0000_000F, 32'h0000_00FF,
                              32'hABCD_0000, 32'h1234_5678, 32'd1};
  logic [31:0] v_exp [12] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd1,
                              32'd0, 32'hFFFF_FF00, 32'hF0F0_F0FF, 32'hFFFF_FFFF,
                              32'h0000_00F0, 32'hABCD_0000, 32'd0, 32'hFFFF_FFEF};

  initial begin
    rst = 1'b1; in_valid = 1'b0; oprs1 = '0; oprs2 = '0; oprd = '0;
    aluop = '0; imm = '0; use_imm = 1'b0; out_ready = 1'b1; dbg_addr = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 32; i++) dbg($sformatf("rst_dbg_x%0d", i), 5'(i), 32'd0);

    // Back-to-back bypass
    issue(5'd1, 5'd0, 5'd0, 4'd0, 32'd5, 1'b1); tick();
    issue(5'd2, 5'd1, 5'd1, 4'd0, 32'd0, 1'b0); tick();
    chk("byp_out1", out_data, 32'd5);
    chk("byp_rd1", {27'd0, out_rd}, 32'd1);
    issue(5'd3, 5'd2, 5'd1, 4'd1, 32'd0, 1'b0); tick();
    chk("byp_out2", out_data, 32'd10);
    in_valid = 1'b0; tick();
    chk("byp_out3", out_data, 32'd5);
    chk("byp_valid3", {31'd0, out_valid}, 32'd1);
    tick();
    chk("byp_drain_valid", {31'd0, out_valid}, 32'd0);
    dbg("byp_dbg_x3", 5'd3, 32'd5);
    chk("byp_retire_cnt", retire_cnt, 32'd3);

    // x0 protection
    issue(5'd0, 5'd0, 5'd0, 4'd0, 32'h1234, 1'b1); tick();
    issue(5'd5, 5'd0, 5'd0, 4'd0, 32'd1, 1'b1); tick();
    chk("x0_out", out_data, 32'h1234);
    chk("x0_rd", {27'd0, out_rd}, 32'd0);
    in_valid = 1'b0; tick();
    chk("x0_x5_out", out_data, 32'd1);
    tick();
    dbg("x0_dbg_x5", 5'd5, 32'd1);
    dbg("x0_dbg_x0", 5'd0, 32'd0);
    chk("x0_retire_cnt", retire_cnt, 32'd5);

    // Signed and logic ops, streamed back-to-back through the bypass
    for (int i = 0; i < 12; i++) begin
      issue((i == 0) ? 5'd1 : 5'(10 + i), (i == 0) ? 5'd0 : 5'd1, 5'd0,
            v_op[i], v_imm[i], 1'b1);
      tick();
      if (i > 0) chk($sformatf("alu_%0d", i - 1), out_data, v_exp[i - 1]);
    end
    in_valid = 1'b0; tick();
    chk("alu_11", out_data, v_exp[11]);
    tick();
    chk("alu_retire_cnt", retire_cnt, 32'd17);
    dbg("alu_dbg_x11", 5'd11, 32'hFFFF_FFFF);

    // Backpressure: 3-cycle stall mid-stream
    issue(5'd20, 5'd0, 5'd0, 4'd0, 32'd100, 1'b1); tick();
    issue(5'd21, 5'd20, 5'd0, 4'd0, 32'd1, 1'b1); tick();
    chk("bp_out_a", out_data, 32'd100);
    issue(5'd22, 5'd21, 5'd0, 4'd0, 32'd1, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold_data_%0d", i), out_data, 32'd100);
      chk($sformatf("bp_hold_rd_%0d", i), {27'd0, out_rd}, 32'd20);
      chk($sformatf("bp_hold_ready_%0d", i), {31'd0, in_ready}, 32'd0);
    end
    chk("bp_cnt_frozen", retire_cnt, 32'd17);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_out_b", out_data, 32'd101);
    issue(5'd23, 5'd22, 5'd0, 4'd0, 32'd1, 1'b1); tick();
    chk("bp_out_c", out_data, 32'd102);
    in_valid = 1'b0; tick();
    chk("bp_out_d", out_data, 32'd103);
    tick();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_retire_cnt", retire_cnt, 32'd21);
    dbg("bp_dbg_x23", 5'd23, 32'd103);

    // Reset mid-stream with S1 and S2 both valid
    issue(5'd24, 5'd0, 5'd0, 4'd0, 32'd77, 1'b1); tick();
    issue(5'd25, 5'd0, 5'd0, 4'd0, 32'd88, 1'b1); tick();
    chk("mrst_s2_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; in_valid = 1'b0; tick();
    rst = 1'b0;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_retire_cnt", retire_cnt, 32'd0);
    dbg("mrst_dbg_x24", 5'd24, 32'd0);
    dbg("mrst_dbg_x23", 5'd23, 32'd0);
    tick();
    chk("mrst_idle_valid", {31'd0, out_valid}, 32'd0);
    dbg("mrst_dbg_x25", 5'd25, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
